// File: rtl/pc_exec_control.sv
// Execution controller: gates PC advance and pipeline-register enables (run / step / pause / breakpoint / halt).
// Latency: commands and stop conditions take effect at the sampling rising edge; i_hazard_stall reaches o_pc_hold combinationally.
// Backpressure: i_hazard_stall only holds the PC; o_pipe_enable follows the registered state alone.
module pc_exec_control #(
    parameter int LEN     = 32,
    parameter int CNT_LEN = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_run,
    input  logic               i_cmd_step,
    input  logic               i_cmd_halt,
    input  logic [CNT_LEN-1:0] i_step_num,
    input  logic               i_hazard_stall,
    input  logic               i_halt_instr,
    input  logic [LEN-1:0]     i_pc,
    input  logic [LEN-1:0]     i_bp_addr,
    input  logic               i_bp_en,
    output logic               o_pc_hold,
    output logic               o_pipe_enable,
    output logic               o_running,
    output logic               o_halted,
    output logic               o_done,
    output logic [CNT_LEN-1:0] o_steps_left,
    output logic [31:0]        o_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_PAUSE,
        S_HALTED
    } state_t;

    localparam logic [CNT_LEN-1:0] STEP_ONE = CNT_LEN'(1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_LEN-1:0] steps_left;
    logic [CNT_LEN-1:0] steps_left_nxt;
    logic               skip;
    logic               skip_nxt;
    logic               done;
    logic               done_nxt;
    logic [31:0]        cycle_count;

    logic pc_at_bp;
    logic bp_hit;
    logic step_go;
    logic pipe_enable;

    assign pc_at_bp    = (i_pc == i_bp_addr);
    // The skip flag masks the breakpoint for the first cycle after resuming from a pause.
    assign bp_hit      = i_bp_en && pc_at_bp && !skip;
    // A zero-length step request is treated as no step request at all.
    assign step_go     = i_cmd_step && (i_step_num != '0);
    assign pipe_enable = (state == S_RUN) || (state == S_STEP);

    // Next-state, step-budget and breakpoint-skip decisions.
    always_comb begin
        state_nxt      = state;
        steps_left_nxt = steps_left;
        skip_nxt       = skip;
        if (!pc_at_bp) begin
            skip_nxt = 1'b0;
        end
        case (state)
            S_IDLE, S_PAUSE: begin
                // Halt outranks step and run, and has nothing to stop here.
                if (!i_cmd_halt) begin
                    if (step_go) begin
                        state_nxt      = S_STEP;
                        steps_left_nxt = i_step_num;
                    end else if (i_cmd_run) begin
                        state_nxt = S_RUN;
                    end
                end
                if (state == S_PAUSE && state_nxt != S_PAUSE) begin
                    skip_nxt = 1'b1;
                end
            end
            S_RUN: begin
                skip_nxt = 1'b0;
                if (i_halt_instr) begin
                    state_nxt = S_HALTED;
                end else if (i_cmd_halt || bp_hit) begin
                    state_nxt = S_PAUSE;
                end
            end
            S_STEP: begin
                skip_nxt = 1'b0;
                if (i_halt_instr) begin
                    state_nxt      = S_HALTED;
                    steps_left_nxt = '0;
                end else if (i_cmd_halt || bp_hit || steps_left == STEP_ONE) begin
                    state_nxt      = S_PAUSE;
                    steps_left_nxt = '0;
                end else begin
                    steps_left_nxt = steps_left - STEP_ONE;
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt      = S_IDLE;
                steps_left_nxt = '0;
                skip_nxt       = 1'b0;
            end
        endcase
        done_nxt = (state_nxt == S_HALTED) && (state != S_HALTED);
    end

    // State, step budget, skip flag, done pulse and saturating enabled-cycle counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            steps_left  <= '0;
            skip        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state      <= state_nxt;
            steps_left <= steps_left_nxt;
            skip       <= skip_nxt;
            done       <= done_nxt;
            if (pipe_enable && cycle_count != 32'hFFFF_FFFF) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    assign o_pipe_enable = pipe_enable;
    assign o_pc_hold     = !pipe_enable || i_hazard_stall;
    assign o_running     = pipe_enable;
    assign o_halted      = (state == S_HALTED);
    assign o_done        = done;
    assign o_steps_left  = steps_left;
    assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pc_exec_control.sv
// Bench for pc_exec_control: directed vector table, hand-written corner sequences,
// then randomized commands checked every cycle against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
module tb_pc_exec_control;

    logic        clk;
    logic        rst;
    logic        cmd_run;
    logic        cmd_step;
    logic        cmd_halt;
    logic [15:0] step_num;
    logic        stall;
    logic        halt_instr;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        pc_hold;
    logic        pipe_enable;
    logic        running;
    logic        halted;
    logic        done;
    logic [15:0] steps_left;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: executing or not, remaining budget (-1 = unbounded run).
    bit          m_active;
    bit          m_halted;
    bit          m_paused;
    bit          m_skip;
    bit          m_done;
    int          m_budget;
    logic [31:0] m_cycles;

    typedef struct {
        logic        rst, run, step, halt;
        logic [15:0] num;
        logic        stall, hinstr;
        logic        e_hold, e_en, e_halted, e_done;
        logic [15:0] e_sl;
        logic [31:0] e_cc;
    } vec_t;

    vec_t tbl[14];

    pc_exec_control #(.LEN(32), .CNT_LEN(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cmd_run      (cmd_run),
        .i_cmd_step     (cmd_step),
        .i_cmd_halt     (cmd_halt),
        .i_step_num     (step_num),
        .i_hazard_stall (stall),
        .i_halt_instr   (halt_instr),
        .i_pc           (pc),
        .i_bp_addr      (bp_addr),
        .i_bp_en        (bp_en),
        .o_pc_hold      (pc_hold),
        .o_pipe_enable  (pipe_enable),
        .o_running      (running),
        .o_halted       (halted),
        .o_done         (done),
        .o_steps_left   (steps_left),
        .o_cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [52:0] dut_vec();
        return {pc_hold, pipe_enable, running, halted, done, steps_left, cycle_count};
    endfunction

    function automatic logic [52:0] model_vec();
        logic [15:0] sl;
        sl = (m_active && m_budget > 0) ? 16'(m_budget) : 16'd0;
        return {(!m_active) || stall, m_active, m_active, m_halted, m_done, sl, m_cycles};
    endfunction

    task automatic compare(input string tag, input logic [52:0] act, input logic [52:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit hit;
        bit launch;
        if (rst) begin
            m_active = 0; m_halted = 0; m_paused = 0; m_skip = 0;
            m_done = 0; m_budget = 0; m_cycles = 0;
        end else if (m_halted) begin
            m_done = 0;
        end else if (m_active) begin
            hit    = bp_en && (pc == bp_addr) && !m_skip;
            m_skip = 0;
            m_done = 0;
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            if (halt_instr) begin
                m_halted = 1; m_active = 0; m_budget = 0; m_done = 1;
            end else if (cmd_halt || hit) begin
                m_active = 0; m_paused = 1; m_budget = 0;
            end else if (m_budget > 0) begin
                m_budget = m_budget - 1;
                if (m_budget == 0) begin
                    m_active = 0; m_paused = 1;
                end
            end
        end else begin
            m_done = 0;
            launch = 0;
            if (pc != bp_addr) m_skip = 0;
            if (!cmd_halt) begin
                if (cmd_step && step_num != 0) begin
                    m_budget = int'(step_num); launch = 1;
                end else if (cmd_run) begin
                    m_budget = -1; launch = 1;
                end
            end
            if (launch) begin
                m_active = 1;
                if (m_paused) m_skip = 1;
            end
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input string tag);
        #1;
        compare(tag, dut_vec(), model_vec());
        clock_edge();
    endtask

    task automatic clear_cmds();
        cmd_run = 0; cmd_step = 0; cmd_halt = 0; halt_instr = 0; rst = 0;
    endtask

    initial begin
        rst = 1; cmd_run = 0; cmd_step = 0; cmd_halt = 0; step_num = 0;
        stall = 0; halt_instr = 0; pc = 32'h0; bp_addr = 32'h10; bp_en = 0;
        clock_edge();
        clock_edge();
        rst = 0;

        //          rst run stp hlt num   stl hin  hold en hlt dn sl  cc
        tbl[0]  = '{0, 0, 0, 0, 16'd0, 0, 0,   1, 0, 0, 0, 16'd0, 32'd0};
        tbl[1]  = '{0, 0, 1, 0, 16'd0, 1, 0,   1, 0, 0, 0, 16'd0, 32'd0};
        tbl[2]  = '{0, 0, 1, 0, 16'd3, 0, 0,   1, 0, 0, 0, 16'd0, 32'd0};
        tbl[3]  = '{0, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 0, 16'd3, 32'd0};
        tbl[4]  = '{0, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 0, 16'd2, 32'd1};
        tbl[5]  = '{0, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 0, 16'd1, 32'd2};
        tbl[6]  = '{0, 1, 0, 0, 16'd0, 0, 0,   1, 0, 0, 0, 16'd0, 32'd3};
        tbl[7]  = '{0, 0, 0, 0, 16'd0, 1, 0,   1, 1, 0, 0, 16'd0, 32'd3};
        tbl[8]  = '{0, 0, 0, 0, 16'd0, 1, 0,   1, 1, 0, 0, 16'd0, 32'd4};
        tbl[9]  = '{0, 0, 0, 0, 16'd0, 0, 0,   0, 1, 0, 0, 16'd0, 32'd5};
        tbl[10] = '{0, 0, 0, 1, 16'd0, 0, 1,   0, 1, 0, 0, 16'd0, 32'd6};
        tbl[11] = '{0, 1, 0, 0, 16'd0, 0, 0,   1, 0, 1, 1, 16'd0, 32'd7};
        tbl[12] = '{0, 0, 1, 0, 16'd4, 0, 0,   1, 0, 1, 0, 16'd0, 32'd7};
        tbl[13] = '{0, 0, 0, 0, 16'd0, 0, 0,   1, 0, 1, 0, 16'd0, 32'd7};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; cmd_run = tbl[i].run; cmd_step = tbl[i].step;
            cmd_halt = tbl[i].halt; step_num = tbl[i].num; stall = tbl[i].stall;
            halt_instr = tbl[i].hinstr;
            #1;
            compare($sformatf("table_row_%0d", i), dut_vec(),
                    {tbl[i].e_hold, tbl[i].e_en, tbl[i].e_en, tbl[i].e_halted,
                     tbl[i].e_done, tbl[i].e_sl, tbl[i].e_cc});
            clock_edge();
        end
        clear_cmds(); stall = 0;

        // Reset in the middle of a 5-cycle step.
        rst = 1; cyc("rst_from_halted"); rst = 0;
        cmd_step = 1; step_num = 16'd5; cyc("step5_issue"); clear_cmds();
        compare("mid_step_left", 53'(steps_left), 53'd5);
        rst = 1; cyc("rst_mid_step"); rst = 0;
        compare("rst_steps_left", 53'(steps_left), 53'd0);
        compare("rst_pipe_enable", 53'(pipe_enable), 53'd0);
        cyc("idle_after_rst");

        // Breakpoint at 0x10: hit, resume without re-trigger, hit again on return.
        bp_addr = 32'h10; bp_en = 1; pc = 32'h08;
        cmd_run = 1; cyc("bp_run"); clear_cmds();
        pc = 32'h0C; cyc("bp_pc0c");
        pc = 32'h10; cyc("bp_pc10");
        compare("bp_pause", 53'(pipe_enable), 53'd0);
        cyc("bp_paused");
        cmd_run = 1; cyc("bp_resume"); clear_cmds();
        compare("bp_resumed", 53'(pipe_enable), 53'd1);
        cyc("bp_still_10");
        compare("bp_no_retrigger", 53'(pipe_enable), 53'd1);
        pc = 32'h14; cyc("bp_pc14");
        pc = 32'h18; cyc("bp_pc18");
        pc = 32'h10; cyc("bp_return");
        compare("bp_second_hit", 53'(pipe_enable), 53'd0);

        // Run and step together in PAUSE: step wins.
        bp_en = 0;
        cmd_run = 1; cmd_step = 1; step_num = 16'd2; cyc("runstep_issue"); clear_cmds();
        compare("runstep_left2", 53'(steps_left), 53'd2);
        cyc("runstep_c1");
        compare("runstep_left1", 53'(steps_left), 53'd1);
        cyc("runstep_c2");
        compare("runstep_paused", 53'({pipe_enable, steps_left}), 53'd0);

        // Randomized phase, PC held whenever the model says execution is stopped.
        bp_addr = 32'h10;
        for (int n = 0; n < 3000; n++) begin
            int r;
            clear_cmds();
            rst = ($urandom_range(0, 249) == 0);
            r = int'($urandom_range(0, 19));
            cmd_run  = (r == 0) || (r == 3);
            cmd_step = (r == 1) || (r == 3);
            cmd_halt = (r == 2);
            step_num = (r == 3) ? 16'($urandom_range(1, 6)) : 16'($urandom_range(0, 6));
            halt_instr = ($urandom_range(0, 399) == 0);
            stall = ($urandom_range(0, 3) == 0);
            bp_en = ($urandom_range(0, 3) != 0);
            if (m_active) pc = 32'h8 + 32'(4 * $urandom_range(0, 6));
            cyc("random");
        end
        clear_cmds();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_exec_control.md
# pc_exec_control

Execution controller for the MIPS pipeline: decides cycle by cycle whether the program counter advances and whether the pipeline stage registers are enabled. It provides continuous run, N-cycle stepping, a pause command, a single-address breakpoint, and a terminal halt on the HALT instruction. It sits between the debug/UART command unit and the fetch stage, and also merges in the hazard unit's load-use stall. All state is updated on the rising edge of i_clk. The PC and pipeline registers sample its outputs on the following falling edge.

## Interface
- LEN, 32, PC width.
- CNT_LEN, 16, step-counter width.
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_run  in  1  one-cycle pulse: start/resume continuous execution.
- i_cmd_step  in  1  one-cycle pulse: execute i_step_num cycles, then pause.
- i_cmd_halt  in  1  one-cycle pulse: pause execution.
- i_step_num  in  CNT_LEN  cycle count for a step command; sampled with i_cmd_step.
- i_hazard_stall  in  1  load-use stall from the hazard unit.
- i_halt_instr  in  1  HALT opcode detected in decode.
- i_pc  in  LEN  current PC value.
- i_bp_addr  in  LEN  breakpoint address.
- i_bp_en  in  1  breakpoint enable.
- o_pc_hold  out  1  1 = PC keeps its value; 0 = PC loads the next value.
- o_pipe_enable  out  1  enable for the stage registers.
- o_running  out  1  state is RUN or STEP.
- o_halted  out  1  state is HALTED.
- o_done  out  1  one-cycle pulse on the cycle HALTED is entered.
- o_steps_left  out  CNT_LEN  remaining step cycles.
- o_cycle_count  out  32  number of cycles with o_pipe_enable=1.

## Operation
- States: IDLE, RUN, STEP, PAUSE, HALTED.
- Reset (i_rst=1 at a rising edge), applied from any state including mid-step:
  - state=IDLE;
  - o_steps_left=0, o_cycle_count=0, o_done=0;
  - breakpoint-skip flag cleared.
- Command priority when several commands are asserted in the same cycle: halt > step > run.
- IDLE / PAUSE:
  - i_cmd_step with i_step_num≠0 → STEP; o_steps_left loads i_step_num.
  - i_cmd_step with i_step_num=0 → ignored.
  - i_cmd_run → RUN.
  - i_cmd_halt → no effect.
  - On leaving PAUSE, set the breakpoint-skip flag.
- RUN, next-state priority:
  - i_halt_instr → HALTED;
  - else i_cmd_halt → PAUSE;
  - else breakpoint hit (i_bp_en && i_pc==i_bp_addr && !skip) → PAUSE.
- STEP, next-state priority:
  - i_halt_instr → HALTED;
  - else i_cmd_halt → PAUSE;
  - else breakpoint hit → PAUSE;
  - else if o_steps_left==1 → PAUSE;
  - otherwise stay in STEP.
  - o_steps_left decrements every cycle spent in STEP, stall cycles included, and reads 0 after any exit from STEP.
- Breakpoint-skip flag:
  - clears after the first enabled cycle in RUN/STEP, so resuming at the breakpoint PC does not re-trigger immediately;
  - also clears whenever i_pc≠i_bp_addr.
- HALTED is terminal. Only i_rst leaves it; commands are ignored.
- Outputs:
  - o_pipe_enable = (state==RUN || state==STEP); registered state decode.
  - o_pc_hold = !o_pipe_enable || i_hazard_stall. This is a combinational path from i_hazard_stall.
  - o_cycle_count increments when o_pipe_enable=1 and saturates at 0xFFFFFFFF.
  - o_done is registered: high exactly one cycle, the first cycle in HALTED.

## Timing
- A command sampled at rising edge k changes state at edge k; o_pipe_enable reflects it from edge k on, i.e. before the falling edge of cycle k.
- A step of N: o_pipe_enable is high for exactly N cycles, then PAUSE, unless ended early by halt, breakpoint or i_halt_instr.
- HALT or breakpoint detection takes effect at the same edge. The PC holds from the following falling edge.
- i_hazard_stall affects o_pc_hold in the same cycle, with no latency. o_pipe_enable is unaffected by the stall.

## Test plan
- Reset → IDLE:
  - expected: o_pc_hold=1, o_pipe_enable=0, o_cycle_count=0, o_steps_left=0.
  - Assert i_rst mid-STEP (o_steps_left=5) → next cycle IDLE, o_steps_left=0.
- Step: i_cmd_step with i_step_num=3 from IDLE:
  - expected: o_pipe_enable high exactly 3 cycles, o_steps_left 3→2→1, then PAUSE with 0, o_cycle_count=3.
  - i_step_num=0 → remains IDLE.
- Run with stall:
  - i_hazard_stall high for 2 cycles → o_pc_hold=1 in those cycles, o_pipe_enable=1, o_cycle_count still increments.
- Breakpoint:
  - setup: i_bp_addr=0x10, i_bp_en=1, run; i_pc reaches 0x10.
  - expected: PAUSE at that edge.
  - i_cmd_run → RUN, no re-trigger while i_pc=0x10.
  - Later i_pc returns to 0x10 → PAUSE again.
- Halt instruction:
  - i_halt_instr in RUN → HALTED, o_done pulses one cycle, o_halted=1.
  - Subsequent i_cmd_run/i_cmd_step → ignored.
  - Same cycle as i_cmd_halt → HALTED wins.
- Simultaneous i_cmd_run + i_cmd_step (i_step_num=2) in PAUSE → STEP for 2 cycles.
